// File: rtl/easy6502_io.sv
// easy6502_io: $FE/$FF I/O decode in front of the 6502 DI bus, with a PS/2 receiver feeding the last-key register.
module easy6502_io #(
    parameter int         TIMEOUT_CYCLES = 25000,
    parameter logic [7:0] LFSR_SEED      = 8'h01
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic [15:0] cpu_address,
    input  logic        cpu_we,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_ready,
    input  logic [7:0]  ram_rdata,
    output logic [7:0]  cpu_rdata,
    output logic        key_strobe,
    output logic        ps2_error
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t        state;
    logic [1:0]    clk_sync, data_sync;
    logic          clk_prev, fall, par_ok;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift, byte_q, key_q, lfsr, key_code;
    logic [TW-1:0] tmo;
    logic          byte_valid, brk, ext, key_hit;
    logic          hit_fe, hit_ff, sel_fe_q, sel_ff_q;

    assign hit_fe = cpu_address == 16'h00FE;
    assign hit_ff = cpu_address == 16'h00FF;
    assign fall   = clk_prev & ~clk_sync[1];

    always_comb begin
        cpu_rdata = sel_fe_q ? lfsr : sel_ff_q ? key_q : ram_rdata;
        key_hit   = byte_valid & ~brk & ~ext & (byte_q inside {8'h1D, 8'h1C, 8'h1B, 8'h23});
        key_code  = byte_q == 8'h1D ? 8'h77 : byte_q == 8'h1C ? 8'h61 : byte_q == 8'h1B ? 8'h73 : 8'h64;
    end

    // Both pins idle high, so the synchronisers reset to 1 to avoid a false edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            clk_prev  <= clk_sync[1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            par_ok     <= 1'b0;
            tmo        <= '0;
            byte_q     <= '0;
            byte_valid <= 1'b0;
            ps2_error  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            ps2_error  <= 1'b0;
            if (state != IDLE && !fall && tmo == TW'(TIMEOUT_CYCLES)) begin
                state     <= IDLE;
                ps2_error <= 1'b1;
            end else begin
                tmo <= (state == IDLE || fall) ? '0 : tmo + 1'b1;
                if (fall) begin
                    case (state)
                        IDLE: begin
                            if (data_sync[1]) ps2_error <= 1'b1;
                            else begin
                                state   <= DATA;
                                bit_cnt <= '0;
                            end
                        end
                        DATA: begin
                            shift   <= {data_sync[1], shift[7:1]};
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == 3'd7) state <= PARITY;
                        end
                        PARITY: begin
                            par_ok <= ^{shift, data_sync[1]};
                            state  <= STOP;
                        end
                        STOP: begin
                            state <= IDLE;
                            if (par_ok && data_sync[1]) begin
                                byte_valid <= 1'b1;
                                byte_q     <= shift;
                            end else ps2_error <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

    // A PS/2 key load takes priority over a same-cycle CPU write to $FF.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr       <= LFSR_SEED;
            sel_fe_q   <= 1'b0;
            sel_ff_q   <= 1'b0;
            key_q      <= '0;
            key_strobe <= 1'b0;
            brk        <= 1'b0;
            ext        <= 1'b0;
        end else begin
            lfsr       <= {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);
            key_strobe <= key_hit;
            if (cpu_ready) begin
                sel_fe_q <= hit_fe;
                sel_ff_q <= hit_ff;
            end
            if (key_hit) key_q <= key_code;
            else if (cpu_we && cpu_ready && hit_ff) key_q <= cpu_wdata;
            if (byte_valid) begin
                if (byte_q == 8'hF0) brk <= 1'b1;
                else if (byte_q == 8'hE0) ext <= 1'b1;
                else begin
                    brk <= 1'b0;
                    ext <= 1'b0;
                end
            end
        end
    end
endmodule
